// File: rtl/bht_access_scheduler.sv
// bht_access_scheduler: arbitrates one single-ported 2-bit-counter BHT between
// fetch lookups and queued execute-stage updates (drained as read-modify-write),
// and sweeps the table to INIT_VAL after reset.
module bht_access_scheduler #(
   parameter int unsigned AW         = 5,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MAX_DEFER  = 8,
   parameter logic [1:0]  INIT_VAL   = 2'b01
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          lk_valid,
   input  logic [AW-1:0] lk_addr,
   output logic          lk_ready,
   output logic          pred_valid,
   output logic          pred_taken,
   input  logic          upd_valid,
   input  logic [AW-1:0] upd_addr,
   input  logic          upd_taken,
   output logic          upd_ready,
   output logic          init_done,
   output logic          bht_en,
   output logic          bht_we,
   output logic [AW-1:0] bht_addr,
   output logic [1:0]    bht_wdata,
   input  logic [1:0]    bht_rdata
);

   localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned PTRW = PW + 1;
   localparam int unsigned DW   = $clog2(MAX_DEFER + 1);

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_IDLE   = 2'd1,
      S_UPD_RD = 2'd2,
      S_UPD_WR = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [AW-1:0]   init_idx;
   logic [AW-1:0]   fifo_addr  [FIFO_DEPTH];
   logic            fifo_taken [FIFO_DEPTH];
   logic [PTRW-1:0] wr_ptr;
   logic [PTRW-1:0] rd_ptr;
   logic            fifo_empty;
   logic            fifo_full;
   logic            push;
   logic            pop;
   logic [AW-1:0]   head_addr;
   logic            head_taken;
   logic [DW-1:0]   defer_cnt;
   logic [DW-1:0]   defer_nxt;
   logic            force_drain;
   logic            lk_accept;
   logic            lk_ready_raw;
   logic            bht_en_raw;
   logic            bht_we_raw;
   logic [1:0]      cnt_sat;

   // FIFO status and head entry
   always_comb begin
      fifo_empty = (wr_ptr == rd_ptr);
      fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
      head_addr  = fifo_addr[rd_ptr[PW-1:0]];
      head_taken = fifo_taken[rd_ptr[PW-1:0]];
      push       = upd_valid && !fifo_full;
      upd_ready  = !fifo_full;
   end

   // Saturating 2-bit counter update of the value read in UPD_RD
   always_comb begin
      cnt_sat = bht_rdata;
      if (head_taken) begin
         if (bht_rdata != 2'b11) cnt_sat = bht_rdata + 2'b01;
      end else begin
         if (bht_rdata != 2'b00) cnt_sat = bht_rdata - 2'b01;
      end
   end

   // Next-state, RAM strobes, lookup handshake and defer bookkeeping
   always_comb begin
      state_nxt    = state;
      lk_ready_raw = 1'b0;
      lk_accept    = 1'b0;
      bht_en_raw   = 1'b0;
      bht_we_raw   = 1'b0;
      bht_addr     = lk_addr;
      bht_wdata    = INIT_VAL;
      pop          = 1'b0;
      defer_nxt    = defer_cnt;
      force_drain  = fifo_full || (defer_cnt >= DW'(MAX_DEFER));

      case (state)
         S_INIT: begin
            bht_en_raw = 1'b1;
            bht_we_raw = 1'b1;
            bht_addr   = init_idx;
            bht_wdata  = INIT_VAL;
            if (init_idx == '1) state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (force_drain) begin
               state_nxt = S_UPD_RD;
            end else begin
               lk_ready_raw = 1'b1;
               if (lk_valid) begin
                  lk_accept  = 1'b1;
                  bht_en_raw = 1'b1;
                  bht_addr   = lk_addr;
                  if (!fifo_empty) begin
                     if (defer_cnt < DW'(MAX_DEFER)) defer_nxt = defer_cnt + DW'(1);
                     // Enter the drain straight after the lookup that exhausts the budget
                     if (defer_nxt >= DW'(MAX_DEFER)) state_nxt = S_UPD_RD;
                  end
               end else if (!fifo_empty) begin
                  state_nxt = S_UPD_RD;
               end
            end
         end
         S_UPD_RD: begin
            bht_en_raw = 1'b1;
            bht_addr   = head_addr;
            defer_nxt  = '0;
            state_nxt  = S_UPD_WR;
         end
         S_UPD_WR: begin
            bht_en_raw = 1'b1;
            bht_we_raw = 1'b1;
            bht_addr   = head_addr;
            bht_wdata  = cnt_sat;
            pop        = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_INIT;
      endcase
   end

   // Strobes are held quiet while reset is asserted
   always_comb begin
      lk_ready   = lk_ready_raw && !rst;
      bht_en     = bht_en_raw && !rst;
      bht_we     = bht_we_raw && !rst;
      pred_taken = pred_valid && bht_rdata[1];
   end

   // State, sweep index, FIFO pointers, defer counter and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_INIT;
         init_idx   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         defer_cnt  <= '0;
         pred_valid <= 1'b0;
         init_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         defer_cnt  <= defer_nxt;
         pred_valid <= lk_accept;
         if (state == S_INIT) begin
            init_idx <= init_idx + AW'(1);
            if (init_idx == '1) init_done <= 1'b1;
         end
         if (push) wr_ptr <= wr_ptr + PTRW'(1);
         if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      end
   end

   // FIFO payload storage
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr[PW-1:0]]  <= upd_addr;
         fifo_taken[wr_ptr[PW-1:0]] <= upd_taken;
      end
   end

endmodule

// File: tb/tb_bht_access_scheduler.sv
// Directed bench for bht_access_scheduler with a behavioural 1-cycle-latency BHT RAM.
module tb_bht_access_scheduler;

   logic       clk;
   logic       rst;
   logic       lk_valid;
   logic [4:0] lk_addr;
   logic       lk_ready;
   logic       pred_valid;
   logic       pred_taken;
   logic       upd_valid;
   logic [4:0] upd_addr;
   logic       upd_taken;
   logic       upd_ready;
   logic       init_done;
   logic       bht_en;
   logic       bht_we;
   logic [4:0] bht_addr;
   logic [1:0] bht_wdata;
   logic [1:0] bht_rdata;

   logic [1:0] mem [32];
   logic       pre_en;
   logic [4:0] pre_addr;
   logic [1:0] pre_val;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [4:0] addr;
      logic [1:0] pre;
      logic       taken;
      logic [1:0] exp;
   } vec_t;

   vec_t vecs [8];

   bht_access_scheduler #(
      .AW(5), .FIFO_DEPTH(4), .MAX_DEFER(8), .INIT_VAL(2'b01)
   ) dut (
      .clk(clk), .rst(rst),
      .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
      .upd_ready(upd_ready), .init_done(init_done),
      .bht_en(bht_en), .bht_we(bht_we), .bht_addr(bht_addr),
      .bht_wdata(bht_wdata), .bht_rdata(bht_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model with a bench-side preload port
   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_val;
      else if (bht_en) begin
         if (bht_we) mem[bht_addr] <= bht_wdata;
         else        bht_rdata     <= mem[bht_addr];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_lookup(input logic [4:0] a, input logic exp_t, input string nm);
      bit ok;
      ok = 1'b0;
      lk_valid = 1'b1;
      lk_addr  = a;
      for (int k = 0; k < 20 && !ok; k++) begin
         #1;
         if (lk_ready) ok = 1'b1;
         adv();
      end
      lk_valid = 1'b0;
      chk({nm, "_accept"}, 32'(ok), 32'(1));
      #1;
      chk({nm, "_pred"}, 32'({pred_valid, pred_taken}), 32'({1'b1, exp_t}));
      adv();
   endtask

   task automatic push_upd(input logic [4:0] a, input logic t);
      bit ok;
      ok = 1'b0;
      upd_valid = 1'b1;
      upd_addr  = a;
      upd_taken = t;
      for (int k = 0; k < 20 && !ok; k++) begin
         #1;
         if (upd_ready) ok = 1'b1;
         adv();
      end
      upd_valid = 1'b0;
   endtask

   task automatic wait_wr(input logic [4:0] a, input logic [1:0] e, input string nm);
      bit         found;
      logic [4:0] ga;
      logic [1:0] gd;
      found = 1'b0;
      ga = '0;
      gd = '0;
      for (int k = 0; k < 20 && !found; k++) begin
         #1;
         if (bht_en && bht_we) begin
            found = 1'b1;
            ga = bht_addr;
            gd = bht_wdata;
         end
         adv();
      end
      chk({nm, "_seen"}, 32'(found), 32'(1));
      chk({nm, "_wr"}, 32'({ga, gd}), 32'({a, e}));
   endtask

   initial begin
      logic [4:0] wq [$];
      logic [4:0] exp_q [4];
      bit         ok;

      vecs[0] = '{5'd5, 2'b00, 1'b0, 2'b00};
      vecs[1] = '{5'd5, 2'b00, 1'b1, 2'b01};
      vecs[2] = '{5'd6, 2'b01, 1'b0, 2'b00};
      vecs[3] = '{5'd6, 2'b01, 1'b1, 2'b10};
      vecs[4] = '{5'd7, 2'b10, 1'b0, 2'b01};
      vecs[5] = '{5'd7, 2'b10, 1'b1, 2'b11};
      vecs[6] = '{5'd8, 2'b11, 1'b0, 2'b10};
      vecs[7] = '{5'd8, 2'b11, 1'b1, 2'b11};

      rst = 1'b1;
      lk_valid = 1'b0; lk_addr = '0;
      upd_valid = 1'b0; upd_addr = '0; upd_taken = 1'b0;
      pre_en = 1'b0; pre_addr = '0; pre_val = '0;

      // Reset state and init sweep
      adv();
      chk("reset_out", 32'({lk_ready, pred_valid, pred_taken, init_done, bht_en, bht_we}), 32'(0));
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         #1;
         chk("init_write", 32'({init_done, bht_en, bht_we, lk_ready, bht_addr, bht_wdata}),
             32'({1'b0, 1'b1, 1'b1, 1'b0, 5'(i), 2'b01}));
         adv();
      end
      #1;
      chk("init_done", 32'({init_done, bht_en, lk_ready}), 32'({1'b1, 1'b0, 1'b1}));
      adv();

      // Lookup after init, then two taken updates on the same entry
      do_lookup(5'd3, 1'b0, "lk3_init");
      push_upd(5'd3, 1'b1);
      wait_wr(5'd3, 2'b10, "upd3_a");
      push_upd(5'd3, 1'b1);
      wait_wr(5'd3, 2'b11, "upd3_b");
      do_lookup(5'd3, 1'b1, "lk3_after");

      // Saturating counter table
      for (int v = 0; v < 8; v++) begin
         pre_en = 1'b1; pre_addr = vecs[v].addr; pre_val = vecs[v].pre;
         adv();
         pre_en = 1'b0;
         push_upd(vecs[v].addr, vecs[v].taken);
         wait_wr(vecs[v].addr, vecs[v].exp, $sformatf("sat%0d", v));
         do_lookup(vecs[v].addr, vecs[v].exp[1], $sformatf("sat%0d_lk", v));
      end

      // Defer limit: one queued update, lookups held high
      upd_valid = 1'b1; upd_addr = 5'd10; upd_taken = 1'b1;
      adv();
      upd_valid = 1'b0;
      lk_valid = 1'b1; lk_addr = 5'd9;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk($sformatf("defer_rdy%0d", k), 32'(lk_ready), 32'((k < 8 || k > 9) ? 1 : 0));
         if (k == 9)
            chk("defer_wr", 32'({bht_en, bht_we, bht_addr, bht_wdata}),
                32'({1'b1, 1'b1, 5'd10, 2'b10}));
         adv();
      end
      lk_valid = 1'b0;
      adv();

      // FIFO fill with a pending lookup; forced drain; updates while full are dropped
      lk_valid = 1'b1; lk_addr = 5'd2;
      upd_valid = 1'b1; upd_taken = 1'b1;
      wq.delete();
      for (int k = 0; k < 7; k++) begin
         upd_addr = (k < 4) ? 5'(11 + k) : 5'd15;
         #1;
         if (k < 4)
            chk($sformatf("fill_rdy%0d", k), 32'({lk_ready, upd_ready}), 32'(2'b11));
         else
            chk($sformatf("full_rdy%0d", k), 32'({lk_ready, upd_ready}), 32'(2'b00));
         if (bht_en && bht_we) wq.push_back(bht_addr);
         adv();
      end
      upd_valid = 1'b0;
      lk_valid = 1'b0;
      #1;
      chk("fifo_not_full", 32'(upd_ready), 32'(1));
      for (int k = 0; k < 20; k++) begin
         #1;
         if (bht_en && bht_we) wq.push_back(bht_addr);
         adv();
      end
      chk("drain_count", 32'(wq.size()), 32'(4));
      exp_q = '{5'd11, 5'd12, 5'd13, 5'd14};
      for (int k = 0; k < 4; k++)
         if (k < wq.size()) chk($sformatf("drain_order%0d", k), 32'(wq[k]), 32'(exp_q[k]));

      // Reset during UPD_WR with a second update still queued
      upd_valid = 1'b1; upd_taken = 1'b0; upd_addr = 5'd20;
      adv();
      upd_addr = 5'd21;
      adv();
      upd_valid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
         #1;
         if (bht_en && bht_we) ok = 1'b1;
         else adv();
      end
      chk("rmw_wr_seen", 32'(ok), 32'(1));
      rst = 1'b1;
      #1;
      chk("rst_gate", 32'({bht_en, bht_we, lk_ready}), 32'(0));
      adv();
      rst = 1'b0;
      #1;
      chk("rst_restart", 32'({bht_en, bht_we, bht_addr, init_done, pred_valid, upd_ready}),
          32'({1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1}));
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         #1;
         if (init_done) ok = 1'b1;
         else adv();
      end
      chk("reinit_done", 32'(ok), 32'(1));
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("fifo_flushed%0d", k), 32'(bht_en), 32'(0));
         adv();
      end
      do_lookup(5'd20, 1'b0, "lk20_reinit");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
